comparador_serie_d_i: RTL

Parametrised right-to-left (LSB-first) sequential magnitude comparator. The block is the multi-cycle successor of the single-bit final comparison cell, and uses the same borrow recurrence (A − B − x). It accepts two WIDTH-bit words and processes DIGITS bits per clock from the LSB upward. It reports A ≥ B (x_p = 0) or A > B (x_p = 1) and a separate equality flag. It sits in the datapath wherever a full-width combinational comparator is too costly in area.

---
 rtl/comparador_serie_d_i.sv | 110 +++++++++++
 1 files changed

// File: rtl/comparador_serie_d_i.sv
// LSB-first serial magnitude comparator: DIGITS bits per clock, borrow recurrence A - B - x.
// Reports A>=B (x_p=0) or A>B (x_p=1) plus equality; N+1 edges from start to done, no queueing.
module comparador_serie_d_i #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_p,
    input  logic [WIDTH-1:0] b_p,
    input  logic             x_p,
    output logic             busy,
    output logic             done,
    output logic             p_x,
    output logic             eq_p
);
    localparam int N     = WIDTH / DIGITS;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || DIGITS < 1 || (WIDTH % DIGITS) != 0) begin : g_bad_params
            $error("comparador_serie_d_i: WIDTH must be >= 1 and a multiple of DIGITS");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   sh_a, sh_b;
    logic [CNT_W-1:0]   cnt;
    logic               brw, eqacc;
    logic               load, step, last;
    logic [DIGITS-1:0]  slice_a, slice_b;
    logic               brw_next, slice_equal;

    // Ripple the borrow through the current slice, bit 0 first.
    always_comb begin
        slice_a     = sh_a[DIGITS-1:0];
        slice_b     = sh_b[DIGITS-1:0];
        slice_equal = (slice_a == slice_b);
        brw_next    = brw;
        for (int i = 0; i < DIGITS; i++) begin
            brw_next = (~slice_a[i] & brw_next) | (slice_b[i] & brw_next) | (~slice_a[i] & slice_b[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CNT_W'(N - 1)) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_a  <= '0;
            sh_b  <= '0;
            cnt   <= '0;
            brw   <= 1'b0;
            eqacc <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            p_x   <= 1'b0;
            eq_p  <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= last;
            if (load) begin
                sh_a  <= a_p;
                sh_b  <= b_p;
                brw   <= x_p;
                eqacc <= 1'b1;
                cnt   <= '0;
            end else if (step) begin
                sh_a  <= sh_a >> DIGITS;
                sh_b  <= sh_b >> DIGITS;
                brw   <= brw_next;
                eqacc <= eqacc & slice_equal;
                cnt   <= cnt + CNT_W'(1);
            end
            // Results only move on the completing edge; a new start leaves them alone.
            if (last) begin
                p_x  <= ~brw_next;
                eq_p <= eqacc & slice_equal;
            end
        end
    end
endmodule
